uart_byte_tx: RTL and testbench
===============================

// Module: uart_byte_tx
// PURPOSE
//  Synthesizable UART transmitter that drives the housekeeping/mgmt UART receive pin (ser_rx) from a byte stream.
//  Bytes enter over a valid/ready push interface into a small FIFO.
//  Each byte is serialised as 8N1: start bit, 8 data bits LSB first, stop bit.
//  Shared by DV benches (stimulus into mprj_io[5]) and by the user-project echo path.
// PARAMETERS
//  DIV_W       16  width of the divisor input; bit period = divisor+1 core_clk cycles
//  FIFO_DEPTH  4   byte FIFO entries; power of two, >= 2
// PORTS
//  core_clk    in   1             single clock, all logic on rising edge
//  core_rst    in   1             asynchronous, active-high reset
//  divisor     in   DIV_W         bit-period divisor; sampled only when a frame starts
//  tx_data     in   8             byte to transmit
//  tx_valid    in   1             tx_data is valid
//  tx_ready    out  1             FIFO can accept; a byte is pushed on an edge with tx_valid&tx_ready
//  ser_tx      out  1             serial line, idle high, registered output
//  busy        out  1             frame in progress or FIFO non-empty
//  fifo_level  out  $clog2(D)+1   current FIFO occupancy
// BEHAVIOUR
//  - Reset values: ser_tx=1, tx_ready=1, busy=0, fifo_level=0. The FSM goes to IDLE and the FIFO is flushed.
//  - Reset mid-frame: ser_tx returns high immediately (asynchronous). The partial frame and queued bytes are discarded.
//  - FIFO:
//    - tx_ready = !full.
//    - Push and pop on the same edge leave the level unchanged.
//    - Pointers wrap modulo FIFO_DEPTH.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE|START.
//  - IDLE:
//    - ser_tx=1.
//    - If the FIFO is non-empty: pop the head into the shift register, latch divisor into the baud counter, set ser_tx=0, go to START.
//    - Latency: a byte accepted at edge E0 into an empty FIFO with the FSM idle gives ser_tx low from edge E1.
//  - Baud counter:
//    - Loads the latched divisor at each bit start and decrements to 0.
//    - At 0 the bit ends, so each bit lasts divisor+1 cycles.
//    - divisor=0 gives 1 cycle per bit, which is legal.
//    - Changes to divisor mid-frame are ignored until the next frame.
//  - DATA: shift right; ser_tx = shreg[0]. A 3-bit bit counter advances from 0 to 7, then the FSM leaves DATA.
//  - STOP:
//    - ser_tx=1 for one bit period.
//    - At the end, if the FIFO is non-empty, pop and go directly to START, with no idle cycle between frames.
//    - Otherwise go to IDLE.
//  - Frame length: 10*(divisor+1) cycles; 11*(divisor+1) with parity.
//  - busy = (state!=IDLE) | (fifo_level!=0). It falls on the edge where STOP ends with the FIFO empty.
//  - tx_valid while tx_ready=0: the byte is held by the source. No drop, no overwrite.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//    - A PARITY state is inserted between DATA and STOP.
//    - ser_tx = even parity, the XOR of the 8 data bits.
//  UART_TX_PARITY_EN undefined: no PARITY state, no parity logic, frame is 8N1 only.
// STRUCTURE
//  uart_defs.vh (shared include):
//    - FSM state encodings: UART_S_IDLE/START/DATA/PARITY/STOP, 3 bits.
//    - UART_DATA_BITS=8.
//    - The same file serves the matching receiver.
//  Sub-module uart_tx_fifo:
//    - Synchronous FIFO, registered pointers, outputs full/empty/level.
//    - Also used for the receive side.
//  The top level holds the FSM, baud counter, bit counter and shift register.
// TESTING
//  1. Reset held, then released, with no input: ser_tx=1, tx_ready=1, busy=0, fifo_level=0 for 100 cycles.
//  2. divisor=3, push 0x41 at E0:
//     - ser_tx low E1..E4.
//     - Data bits 1,0,0,0,0,0,1,0, 4 cycles each.
//     - Stop high 4 cycles; busy drops at E41.
//  3. divisor=15, push 0x01..0x06 back-to-back:
//     - 0x01..0x05 accepted on E0..E4.
//     - tx_ready low from E4 until the 0x02 pop at the end of frame 1.
//     - Frames are contiguous, with no idle bit between them.
//  4. divisor changes from 3 to 7 during frame 1: frame 1 stays at 4 cycles/bit, frame 2 uses 8 cycles/bit.
//  5. core_rst asserted in the middle of the DATA bits of frame 1 with 3 bytes queued:
//     - ser_tx goes to 1 immediately and fifo_level=0.
//     - After release, no further frame is emitted.
//  6. With UART_TX_PARITY_EN defined, divisor=1:
//     - 0x41 yields parity bit 0; 0x07 yields parity bit 1.
//     - Frame length is 22 cycles.
//     - A loopback into tbuart-style receiver decodes both bytes.

Source files
------------

// File: rtl/uart_byte_tx_pkg.sv
// Shared types for the byte UART transmitter and its matching receiver.
// The FSM state encoding is fixed at 3 bits so both sides agree.
package uart_byte_tx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    UART_S_IDLE   = 3'd0,
    UART_S_START  = 3'd1,
    UART_S_DATA   = 3'd2,
    UART_S_PARITY = 3'd3,
    UART_S_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_byte_tx_if.sv
// Valid/ready byte push channel into the UART transmitter.
// The source drives data/valid and holds them until ready is seen.
interface uart_byte_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO with registered pointers and level.
// Shared by the transmit and receive paths; DEPTH must be a power of two.
module uart_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_push, do_pop;

  assign full  = (lvl_q == LW'(DEPTH));
  assign empty = (lvl_q == '0);
  assign level = lvl_q;
  assign dout  = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    lvl_d   = lvl_q;
    if (do_push && !do_pop) begin
      lvl_d = lvl_q + LW'(1);
    end else if (do_pop && !do_push) begin
      lvl_d = lvl_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; drives the mgmt ser_rx pin.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_byte_tx
  import uart_byte_tx_pkg::*;
#(
  parameter  int DIV_W      = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic [DIV_W-1:0] divisor,
  uart_byte_tx_if.slave    tx,
  output logic             ser_tx,
  output logic             busy,
  output logic [LW-1:0]    fifo_level
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic             ser_q, ser_d;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic       full, empty, pop, load, bit_end;
  logic [7:0] head;

  assign tx.tx_ready = ~full;
  assign ser_tx      = ser_q;
  assign busy        = (state_q != UART_S_IDLE) | (fifo_level != '0);
  assign bit_end     = (baud_q == '0);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (core_clk),
    .rst   (core_rst),
    .push  (tx.tx_valid),
    .din   (tx.tx_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q <= UART_S_IDLE;
      shreg_q <= '0;
      baud_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UART_S_IDLE: begin
        if (!empty) state_d = UART_S_START;
      end
      UART_S_START: begin
        if (bit_end) state_d = UART_S_DATA;
      end
      UART_S_DATA: begin
        if (bit_end && bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          state_d = UART_S_PARITY;
`else
          state_d = UART_S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_S_PARITY: begin
        if (bit_end) state_d = UART_S_STOP;
      end
`endif
      UART_S_STOP: begin
        if (bit_end) begin
          state_d = empty ? UART_S_IDLE : UART_S_START;
        end
      end
      default: state_d = UART_S_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    load    = 1'b0;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    ser_d   = ser_q;
    baud_d  = bit_end ? baud_q : baud_q - DIV_W'(1);
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      UART_S_IDLE: begin
        ser_d = 1'b1;
        load  = ~empty;
      end
      UART_S_START: begin
        if (bit_end) begin
          ser_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bit_d   = '0;
          baud_d  = div_q;
        end
      end
      UART_S_DATA: begin
        if (bit_end) begin
          baud_d = div_q;
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            ser_d = par_q;
`else
            ser_d = 1'b1;
`endif
          end else begin
            ser_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_S_PARITY: begin
        if (bit_end) begin
          ser_d  = 1'b1;
          baud_d = div_q;
        end
      end
`endif
      UART_S_STOP: begin
        if (bit_end) load = ~empty;
      end
      default: ser_d = 1'b1;
    endcase
    // Frame start: divisor is captured here and held for the whole frame.
    if (load) begin
      pop     = 1'b1;
      shreg_d = head;
      baud_d  = divisor;
      div_d   = divisor;
      ser_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: table of single frames plus
// back-to-back, divisor-change and mid-frame reset sequences.
module tb_uart_byte_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b1;
  logic [15:0] divisor  = 16'd3;
  logic        ser_tx, busy;
  logic [2:0]  fifo_level;

  uart_byte_tx_if bus ();

  uart_byte_tx #(
    .DIV_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .core_clk   (core_clk),
    .core_rst   (core_rst),
    .divisor    (divisor),
    .tx         (bus.slave),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 core_clk = ~core_clk;

  int n_chk = 0;
  int n_err = 0;
  int acc_edge [8];

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    logic [9:0]  frame;
    logic        par;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic fbit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Called at a negedge; offers each byte until accepted.
  task automatic push_seq(input int n, input logic [7:0] d [8]);
    int  e;
    logic r, acc;
    e = 0;
    for (int i = 0; i < n; i++) begin
      bus.tx_data  = d[i];
      bus.tx_valid = 1'b1;
      acc = 1'b0;
      while (!acc && e < 2000) begin
        r = bus.tx_ready;
        @(posedge core_clk);
        if (r) begin
          acc = 1'b1;
          acc_edge[i] = e;
        end
        e++;
        @(negedge core_clk);
      end
      if (!acc) chk("push_timeout", 32'(i), 32'hFFFF);
    end
    bus.tx_valid = 1'b0;
  endtask

  // Called between E0 and E1; checks frames starting at E1.
  task automatic check_frames(input int nfr, input logic [7:0] d [8],
                              input int per [8]);
    for (int f = 0; f < nfr; f++) begin
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < per[f]; k++) begin
          @(posedge core_clk);
          #1;
          chk($sformatf("stream f%0d b%0d", f, b),
              {30'd0, busy, ser_tx}, {30'd0, 1'b1, fbit(d[f], b)});
        end
      end
    end
    @(posedge core_clk);
    #1;
    chk("stream_end", {29'd0, busy, ser_tx, bus.tx_ready}, 32'b011);
  endtask

  logic [7:0] bq [8];
  int         per [8];
  logic [7:0] one [8];
  logic       eb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'd3, 8'h41, 10'b1010000010, 1'b0};
    vecs[1] = '{16'd0, 8'hA5, 10'b1101001010, 1'b0};
    vecs[2] = '{16'd1, 8'h07, 10'b1000001110, 1'b1};
    vecs[3] = '{16'd2, 8'hFF, 10'b1111111110, 1'b0};
    vecs[4] = '{16'd1, 8'h00, 10'b1000000000, 1'b0};
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    repeat (3) @(posedge core_clk);
    #1;
    chk("in_reset", {28'd0, ser_tx, bus.tx_ready, busy, fifo_level[0]},
        32'b1100);
    @(negedge core_clk);
    core_rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(posedge core_clk);
      #1;
      chk("idle", {26'd0, ser_tx, bus.tx_ready, busy, fifo_level},
          {26'd0, 1'b1, 1'b1, 1'b0, 3'd0});
    end

    for (int v = 0; v < 5; v++) begin
      @(negedge core_clk);
      divisor = vecs[v].div;
      one[0] = vecs[v].data;
      push_seq(1, one);
      chk($sformatf("v%0d lvl_after_push", v), {29'd0, fifo_level}, 32'd1);
      for (int b = 0; b < NB; b++) begin
`ifdef UART_TX_PARITY_EN
        eb = (b < 9) ? vecs[v].frame[b] : (b == 9) ? vecs[v].par : 1'b1;
`else
        eb = vecs[v].frame[b];
`endif
        for (int k = 0; k <= int'(vecs[v].div); k++) begin
          @(posedge core_clk);
          #1;
          chk($sformatf("v%0d bit%0d", v, b), {30'd0, busy, ser_tx},
              {30'd0, 1'b1, eb});
        end
      end
      @(posedge core_clk);
      #1;
      chk($sformatf("v%0d busy_drop", v), {29'd0, busy, ser_tx, fifo_level[0]},
          32'b010);
    end

    @(negedge core_clk);
    divisor = 16'd15;
    for (int i = 0; i < 8; i++) begin
      bq[i]  = 8'(i + 1);
      per[i] = 16;
    end
    fork
      push_seq(6, bq);
      begin
        @(posedge core_clk);
        check_frames(6, bq, per);
      end
      begin
        repeat (5) @(posedge core_clk);
        #1;
        chk("full_ready", {28'd0, bus.tx_ready, fifo_level}, 32'd4);
      end
    join
    for (int i = 0; i < 5; i++) chk($sformatf("acc_edge%0d", i),
                                    32'(acc_edge[i]), 32'(i));
    chk("acc_edge5", 32'(acc_edge[5]), 32'(2 + NB * 16));

    @(negedge core_clk);
    divisor = 16'd3;
    bq[0] = 8'h41;
    bq[1] = 8'h55;
    per[0] = 4;
    per[1] = 8;
    fork
      push_seq(2, bq);
      begin
        @(posedge core_clk);
        check_frames(2, bq, per);
      end
      begin
        repeat (11) @(posedge core_clk);
        #2;
        divisor = 16'd7;
      end
    join

    @(negedge core_clk);
    divisor = 16'd3;
    for (int i = 0; i < 8; i++) bq[i] = 8'h00;
    fork
      push_seq(4, bq);
      begin
        repeat (16) @(posedge core_clk);
        #2;
        chk("pre_rst", {29'd0, ser_tx, fifo_level}, 32'd3);
        #1;
        core_rst = 1'b1;
        #1;
        chk("async_rst", {27'd0, ser_tx, bus.tx_ready, busy, fifo_level},
            {27'd0, 1'b1, 1'b1, 1'b0, 3'd0});
      end
    join
    @(negedge core_clk);
    core_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge core_clk);
      #1;
      chk("post_rst", {26'd0, ser_tx, busy, fifo_level}, 32'b10000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
